// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU command sequencer and its register file.
package alu_seq_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;

  localparam logic [2:0] MODE_ADD = 3'd0;
  localparam logic [2:0] MODE_SUB = 3'd1;
  localparam logic [2:0] MODE_CMP = 3'd2;
  localparam logic [2:0] MODE_AND = 3'd3;
  localparam logic [2:0] MODE_OR  = 3'd4;
  localparam logic [2:0] MODE_NOT = 3'd5;
  localparam logic [2:0] MODE_INC = 3'd6;
  localparam logic [2:0] MODE_DEC = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // Only add and subtract produce a meaningful overflow.
  // The ALU floats that output in every other mode.
  function automatic logic modeSetsFlag(input logic [2:0] mode);
    return (mode == MODE_ADD) || (mode == MODE_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file for the sequencer.
// It has two combinational operand read ports, a combinational debug read port,
// and one synchronous write port.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddrA_i,
  output logic [DATA_W-1:0] rdataA_o,
  input  logic [ADDR_W-1:0] raddrB_i,
  output logic [DATA_W-1:0] rdataB_o,
  input  logic [ADDR_W-1:0] dbgAddr_i,
  output logic [DATA_W-1:0] dbgData_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Storage array: reset clears every entry.
  // Otherwise one entry is written per clock whenever the sequencer requests it.
  // Register 0 is an ordinary register here and is never forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdataA_o  = mem_q[raddrA_i];
  assign rdataB_o  = mem_q[raddrB_i];
  assign dbgData_o = mem_q[dbgAddr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer sitting in front of an external 4-bit ALU.
// It accepts one command at a time, drives registered operands into the ALU,
// writes the result back into the register file and returns it on a response
// channel. A sticky overflow flag can be chained into the next add as carry-in.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_mode,
  input  logic [1:0] cmd_src_a,
  input  logic [1:0] cmd_src_b,
  input  logic [1:0] cmd_dst,
  input  logic [3:0] cmd_imm,
  input  logic       cmd_use_carry,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_mode,
  input  logic [3:0] alu_r,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_overflow,
  output logic       flag_v,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  seq_state_e  state_q, state_d;
  logic [3:0]  aluA_q, aluA_d;
  logic [3:0]  aluB_q, aluB_d;
  logic        aluCin_q, aluCin_d;
  logic [2:0]  aluMode_q, aluMode_d;
  logic [1:0]  dst_q, dst_d;
  logic [3:0]  rspData_q, rspData_d;
  logic        rspOvf_q, rspOvf_d;
  logic        flagV_q, flagV_d;

  logic        wrEn;
  logic [1:0]  wrAddr;
  logic [3:0]  wrData;
  logic [3:0]  rdA;
  logic [3:0]  rdB;

  alu_seq_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wrEn),
    .waddr_i  (wrAddr),
    .wdata_i  (wrData),
    .raddrA_i (cmd_src_a),
    .rdataA_o (rdA),
    .raddrB_i (cmd_src_b),
    .rdataB_o (rdB),
    .dbgAddr_i(dbg_addr),
    .dbgData_o(dbg_data)
  );

  // State and datapath registers.
  // An async reset drops any in-flight command and its pending response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluCin_q  <= 1'b0;
      aluMode_q <= MODE_ADD;
      dst_q     <= '0;
      rspData_q <= '0;
      rspOvf_q  <= 1'b0;
      flagV_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluCin_q  <= aluCin_d;
      aluMode_q <= aluMode_d;
      dst_q     <= dst_d;
      rspData_q <= rspData_d;
      rspOvf_q  <= rspOvf_d;
      flagV_q   <= flagV_d;
    end
  end

  // Next-state and handshake logic.
  // Every register holds by default, so the ALU inputs stay frozen outside the
  // accept cycle. A load skips the ALU and goes straight to the response.
  // An ALU operation spends one cycle in EXEC while the external ALU settles,
  // and the result is written back on the edge that leaves EXEC.
  always_comb begin
    state_d   = state_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    aluCin_d  = aluCin_q;
    aluMode_d = aluMode_q;
    dst_d     = dst_q;
    rspData_d = rspData_q;
    rspOvf_d  = rspOvf_q;
    flagV_d   = flagV_q;
    wrEn      = 1'b0;
    wrAddr    = dst_q;
    wrData    = alu_r;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_load) begin
            wrEn      = 1'b1;
            wrAddr    = cmd_dst;
            wrData    = cmd_imm;
            rspData_d = cmd_imm;
            rspOvf_d  = flagV_q;
            state_d   = RESP;
          end else begin
            aluA_d    = rdA;
            aluB_d    = rdB;
            aluMode_d = cmd_mode;
            aluCin_d  = cmd_use_carry & flagV_q;
            dst_d     = cmd_dst;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        wrEn      = 1'b1;
        wrAddr    = dst_q;
        wrData    = alu_r;
        rspData_d = alu_r;
        if (modeSetsFlag(aluMode_q)) begin
          flagV_d  = alu_overflow;
          rspOvf_d = alu_overflow;
        end else begin
          rspOvf_d = flagV_q;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign alu_a        = aluA_q;
  assign alu_b        = aluB_q;
  assign alu_cin      = aluCin_q;
  assign alu_mode     = aluMode_q;
  assign rsp_data     = rspData_q;
  assign rsp_overflow = rspOvf_q;
  assign flag_v       = flagV_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer.
// A stand-in ALU closes the loop. A transaction-level model of the register file
// and flag is compared against the DUT on every falling edge, and directed
// commands carry hand-computed results.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_mode;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic [1:0] cmd_dst;
  logic [3:0] cmd_imm;
  logic       cmd_use_carry;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [2:0] alu_mode;
  logic [3:0] alu_r;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_overflow;
  logic       flag_v;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(
    .NREGS(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load     (cmd_load),
    .cmd_mode     (cmd_mode),
    .cmd_src_a    (cmd_src_a),
    .cmd_src_b    (cmd_src_b),
    .cmd_dst      (cmd_dst),
    .cmd_imm      (cmd_imm),
    .cmd_use_carry(cmd_use_carry),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_mode     (alu_mode),
    .alu_r        (alu_r),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .flag_v       (flag_v),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference 4-bit ALU: bit 4 is carry-out for add and borrow for subtract.
  // Compare packs {lt, eq, gt} into the low bits.
  function automatic logic [4:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic [2:0] mode);
    logic [4:0] r;
    r = 5'd0;
    case (mode)
      3'd0: r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      3'd1: r = {1'b0, a} - {1'b0, b} - {4'd0, cin};
      3'd2: r = {2'b00, (a < b), (a == b), (a > b)};
      3'd3: r = {1'b0, a & b};
      3'd4: r = {1'b0, a | b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {1'b0, a + 4'd1};
      default: r = {1'b0, a - 4'd1};
    endcase
    return r;
  endfunction

  // Stand-in for the external ALU, driven combinationally from the DUT's registered outputs.
  // Outside add and subtract the real ALU floats its overflow output, and this
  // stand-in drives 0 there. A DUT that samples it in those modes would wrongly
  // clear a set flag.
  logic [4:0] aluOut;
  always_comb begin
    aluOut = aluRef(alu_a, alu_b, alu_cin, alu_mode);
  end
  assign alu_r        = aluOut[3:0];
  assign alu_overflow = (alu_mode <= 3'd1) ? aluOut[4] : 1'b0;

  // Transaction-level model: register contents, flag, and the last response.
  // A command is pending from its acceptance until its response is taken.
  logic [3:0] mRegs [4];
  logic       mFlag     = 1'b0;
  logic [3:0] mRsp      = 4'd0;
  logic       mRspOv    = 1'b0;
  logic [3:0] mAluA     = 4'd0;
  logic [3:0] mAluB     = 4'd0;
  logic       mAluCin   = 1'b0;
  logic [2:0] mAluMode  = 3'd0;
  logic [1:0] mDst      = 2'd0;
  logic       mPending  = 1'b0;
  logic       mExecDue  = 1'b0;
  int         mAcceptCnt = 0;
  logic [4:0] mExecRes;

  assign mExecRes = aluRef(mAluA, mAluB, mAluCin, mAluMode);

  // Update the model at each rising edge from the same inputs the DUT sees.
  // Reset clears the whole model immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mRegs[i] <= 4'd0;
      mFlag <= 1'b0; mRsp <= 4'd0; mRspOv <= 1'b0;
      mAluA <= 4'd0; mAluB <= 4'd0; mAluCin <= 1'b0; mAluMode <= 3'd0;
      mDst <= 2'd0; mPending <= 1'b0; mExecDue <= 1'b0;
    end else if (!mPending) begin
      if (cmd_valid) begin
        mAcceptCnt <= mAcceptCnt + 1;
        mPending   <= 1'b1;
        if (cmd_load) begin
          mRegs[cmd_dst] <= cmd_imm;
          mRsp           <= cmd_imm;
          mRspOv         <= mFlag;
        end else begin
          mAluA    <= mRegs[cmd_src_a];
          mAluB    <= mRegs[cmd_src_b];
          mAluCin  <= cmd_use_carry & mFlag;
          mAluMode <= cmd_mode;
          mDst     <= cmd_dst;
          mExecDue <= 1'b1;
        end
      end
    end else if (mExecDue) begin
      mRegs[mDst] <= mExecRes[3:0];
      mRsp        <= mExecRes[3:0];
      mExecDue    <= 1'b0;
      if (mAluMode <= 3'd1) begin
        mFlag  <= mExecRes[4];
        mRspOv <= mExecRes[4];
      end else begin
        mRspOv <= mFlag;
      end
    end else if (rsp_ready) begin
      mPending <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge, away from the active edge.
  always @(negedge clk) begin
    checkOutput("cmd_ready",    {7'd0, cmd_ready},    {7'd0, !mPending});
    checkOutput("rsp_valid",    {7'd0, rsp_valid},    {7'd0, mPending && !mExecDue});
    checkOutput("rsp_data",     {4'd0, rsp_data},     {4'd0, mRsp});
    checkOutput("rsp_overflow", {7'd0, rsp_overflow}, {7'd0, mRspOv});
    checkOutput("flag_v",       {7'd0, flag_v},       {7'd0, mFlag});
    checkOutput("alu_a",        {4'd0, alu_a},        {4'd0, mAluA});
    checkOutput("alu_b",        {4'd0, alu_b},        {4'd0, mAluB});
    checkOutput("alu_cin",      {7'd0, alu_cin},      {7'd0, mAluCin});
    checkOutput("alu_mode",     {5'd0, alu_mode},     {5'd0, mAluMode});
    checkOutput("dbg_data",     {4'd0, dbg_data},     {4'd0, mRegs[dbg_addr]});
  end

  // Present one command, hold it until accepted, then return with inputs idle.
  // The caller is left one step after the accept edge.
  task automatic applyStimulus(input logic load, input logic [2:0] mode, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] dst, input logic [3:0] imm,
                               input logic useCarry, input string name);
    int startCnt;
    bit got;
    startCnt      = mAcceptCnt;
    got           = 1'b0;
    cmd_load      = load;
    cmd_mode      = mode;
    cmd_src_a     = a;
    cmd_src_b     = b;
    cmd_dst       = dst;
    cmd_imm       = imm;
    cmd_use_carry = useCarry;
    dbg_addr      = dst;
    cmd_valid     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (mAcceptCnt != startCnt) begin
        got = 1'b1;
        break;
      end
    end
    cmd_valid     = 1'b0;
    cmd_mode      = 3'($urandom_range(0, 7));
    cmd_imm       = 4'($urandom_range(0, 15));
    cmd_use_carry = 1'($urandom_range(0, 1));
    if (!got) checkOutput({name, " accept"}, 8'd0, 8'd1);
  endtask

  // Run one command end to end with rsp_ready held high, checking literal expectations.
  task automatic runCommand(input logic load, input logic [2:0] mode, input logic [1:0] a,
                            input logic [1:0] b, input logic [1:0] dst, input logic [3:0] imm,
                            input logic useCarry, input logic expCin, input logic [3:0] expData,
                            input logic expFlag, input string name);
    applyStimulus(load, mode, a, b, dst, imm, useCarry, name);
    if (!load) begin
      checkOutput({name, " exec rsp_valid"}, {7'd0, rsp_valid}, 8'd0);
      checkOutput({name, " exec alu_cin"},   {7'd0, alu_cin},   {7'd0, expCin});
      @(posedge clk);
      #1;
    end
    checkOutput({name, " rsp_valid"},    {7'd0, rsp_valid},    8'd1);
    checkOutput({name, " rsp_data"},     {4'd0, rsp_data},     {4'd0, expData});
    checkOutput({name, " rsp_overflow"}, {7'd0, rsp_overflow}, {7'd0, expFlag});
    checkOutput({name, " flag_v"},       {7'd0, flag_v},       {7'd0, expFlag});
    @(posedge clk);
    #1;
    checkOutput({name, " back to idle"}, {7'd0, cmd_ready}, 8'd1);
    checkOutput({name, " dbg writeback"}, {4'd0, dbg_data}, {4'd0, expData});
  endtask

  // Watchdog so the run always ends even if the flow stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed flow.
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_mode = 3'd0;
    cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd0; cmd_imm = 4'd0;
    cmd_use_carry = 1'b0; rsp_ready = 1'b1; dbg_addr = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset cmd_ready", {7'd0, cmd_ready}, 8'd1);
    checkOutput("reset rsp_valid", {7'd0, rsp_valid}, 8'd0);
    checkOutput("reset flag_v",    {7'd0, flag_v},    8'd0);
    checkOutput("reset rsp_data",  {4'd0, rsp_data},  8'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checkOutput("reset dbg_data", {4'd0, dbg_data}, 8'd0);
    end
    @(posedge clk);
    #1;

    // Loads: response one cycle after accept, flag untouched.
    runCommand(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h7, 1'b0, 1'b0, 4'h7, 1'b0, "load r0");
    runCommand(1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 4'h9, 1'b0, 1'b0, 4'h9, 1'b0, "load r1");
    runCommand(1'b1, 3'd0, 2'd0, 2'd0, 2'd2, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0, "load r2");
    runCommand(1'b1, 3'd0, 2'd0, 2'd0, 2'd3, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, "load r3");

    // Chained add: F+1 carries out, then 9+9+carry = 0x13.
    runCommand(1'b0, 3'd0, 2'd2, 2'd3, 2'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, "add r2+r3");
    runCommand(1'b0, 3'd0, 2'd1, 2'd1, 2'd1, 4'h0, 1'b1, 1'b1, 4'h3, 1'b1, "add r1+r1+c");

    // Non-arithmetic modes leave the flag set.
    runCommand(1'b0, 3'd5, 2'd1, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0, 4'hC, 1'b1, "not r1");
    runCommand(1'b0, 3'd4, 2'd0, 2'd3, 2'd2, 4'h0, 1'b0, 1'b0, 4'hD, 1'b1, "or r0|r3");
    runCommand(1'b0, 3'd3, 2'd2, 2'd1, 2'd3, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1, "and r2&r1");
    runCommand(1'b0, 3'd6, 2'd2, 2'd0, 2'd1, 4'h0, 1'b1, 1'b1, 4'hE, 1'b1, "inc r2");
    runCommand(1'b0, 3'd7, 2'd3, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, "dec r3");
    runCommand(1'b0, 3'd2, 2'd1, 2'd2, 2'd0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1, "cmp r1,r2");

    // Subtract without borrow clears the flag: D-1 = C.
    runCommand(1'b0, 3'd1, 2'd2, 2'd3, 2'd0, 4'h0, 1'b0, 1'b0, 4'hC, 1'b0, "sub r2-r3");

    // Backpressure: hold the response and offer a competing command.
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 2'd0, 2'd0, 2'd3, 4'h5, 1'b0, "bp load r3");
    cmd_load = 1'b1; cmd_dst = 2'd2; cmd_imm = 4'hA; cmd_valid = 1'b1;
    dbg_addr = 2'd2;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp rsp_valid", {7'd0, rsp_valid}, 8'd1);
      checkOutput("bp rsp_data",  {4'd0, rsp_data},  8'h05);
      checkOutput("bp cmd_ready", {7'd0, cmd_ready}, 8'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("bp r2 untouched", {4'd0, dbg_data}, 8'h0D);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp release rsp_valid", {7'd0, rsp_valid}, 8'd0);
    checkOutput("bp release cmd_ready", {7'd0, cmd_ready}, 8'd1);
    checkOutput("bp r2 still", {4'd0, dbg_data}, 8'h0D);

    // Reset during EXEC: no write-back, no response.
    applyStimulus(1'b0, 3'd0, 2'd1, 2'd2, 2'd1, 4'h0, 1'b0, "rst add");
    checkOutput("rst pre exec rsp_valid", {7'd0, rsp_valid}, 8'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst cmd_ready", {7'd0, cmd_ready}, 8'd1);
    checkOutput("rst rsp_valid", {7'd0, rsp_valid}, 8'd0);
    checkOutput("rst r1 cleared", {4'd0, dbg_data}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post rst rsp_valid", {7'd0, rsp_valid}, 8'd0);
      checkOutput("post rst cmd_ready", {7'd0, cmd_ready}, 8'd1);
      checkOutput("post rst r1", {4'd0, dbg_data}, 8'd0);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checkOutput("post rst regs", {4'd0, dbg_data}, 8'd0);
    end
    checkOutput("post rst flag_v", {7'd0, flag_v}, 8'd0);

    // Register 0 is writable after reset.
    runCommand(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h6, 1'b0, 1'b0, 4'h6, 1'b0, "load r0 again");

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command sequencer and 4×4-bit register file that sits directly upstream of the 4-bit ALU and also consumes its output. It accepts one command at a time over a valid/ready handshake and drives registered operands, carry-in and mode into the ALU. It writes the ALU result back into the register file and returns it on a valid/ready response channel. It keeps a sticky overflow flag that can be chained into the next add as carry-in.

## Interface
Parameters:
- NREGS, 4, register-file depth; fixed at 4, so addresses are 2 bits.

Ports (reset is asynchronous and active-low):
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_load  in  1  1 = write cmd_imm to cmd_dst without using the ALU; 0 = ALU operation
- cmd_mode  in  3  ALU mode: 0 add, 1 sub, 2 compare, 3 AND, 4 OR, 5 NOT A, 6 A+1, 7 A-1
- cmd_src_a  in  2  register-file address for operand A
- cmd_src_b  in  2  register-file address for operand B
- cmd_dst  in  2  write-back address
- cmd_imm  in  4  immediate value for load
- cmd_use_carry  in  1  when 1, ALU Cin = flag_v; when 0, Cin = 0
- alu_a, alu_b  out  4  registered operands to the ALU
- alu_cin  out  1  registered carry-in to the ALU
- alu_mode  out  3  registered mode to the ALU
- alu_r  in  4  ALU result (combinational from alu_*)
- alu_overflow  in  1  ALU overflow; meaningful only for modes 0 and 1
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  4  written-back value
- rsp_overflow  out  1  flag_v after this command
- flag_v  out  1  sticky overflow/carry flag
- dbg_addr  in  2  register-file read address
- dbg_data  out  4  combinational read of regfile[dbg_addr]

## Operation
The sequencer has three states: IDLE, EXEC and RESP.

IDLE
- cmd_ready = 1.
- On cmd_valid & cmd_ready with cmd_load = 1: regfile[cmd_dst] <= cmd_imm, rsp_data <= cmd_imm, go to RESP. flag_v is unchanged.
- On cmd_valid & cmd_ready with cmd_load = 0:
  - alu_a <= regfile[cmd_src_a], alu_b <= regfile[cmd_src_b]
  - alu_mode <= cmd_mode, alu_cin <= cmd_use_carry & flag_v
  - latch cmd_dst, go to EXEC.

EXEC
- cmd_ready = 0.
- At the clock edge: regfile[dst] <= alu_r, rsp_data <= alu_r.
- If alu_mode ∈ {0,1}: flag_v <= alu_overflow. Otherwise flag_v is held. The input is never sampled in modes 2–7, where the ALU drives it high-Z.
- Go to RESP.

RESP
- rsp_valid = 1 and cmd_ready = 0.
- On rsp_ready, go to IDLE.
- rsp_data and rsp_overflow are stable while rsp_valid = 1 and rsp_ready = 0.

Width rules: all arithmetic is 4-bit, performed inside the ALU. The sequencer performs no arithmetic.

Hazards: commands are fully serialized, so a source equal to the previous destination always reads the written-back value.

## Timing
Reset values of all outputs:
- state = IDLE, cmd_ready = 1, rsp_valid = 0
- rsp_data = 0, rsp_overflow = 0, flag_v = 0
- alu_a = alu_b = 0, alu_cin = 0, alu_mode = 0
- all registers = 0

Latency:
- ALU command: accepted in cycle 0, EXEC in cycle 1, rsp_valid high from cycle 2.
- Load: rsp_valid high from cycle 1.
- Minimum spacing: one ALU command per 3 cycles; one load per 2 cycles (rsp_ready tied high).

Boundary conditions:
- The IDLE→(EXEC|RESP) transition happens only on the accept edge. cmd_* values are don't-care outside an accepted cycle.
- alu_* outputs hold their last values in IDLE and RESP.
- rsp_ready asserted outside RESP is ignored.
- rst_n falling mid-operation (EXEC or RESP) immediately returns the block to its reset values. No write-back occurs, and the pending response is dropped.
- A write to register 0 is legal; there is no hard-wired zero register.
- dbg_data reflects a write on the cycle after the write edge.

## Structure
- Package alu_seq_pkg holds:
  - mode constants: MODE_ADD = 0, MODE_SUB = 1, MODE_CMP = 2, MODE_AND = 3, MODE_OR = 4, MODE_NOT = 5, MODE_INC = 6, MODE_DEC = 7
  - state encoding: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2
- Sub-module alu_seq_regfile: 4×4 bits with two combinational read ports plus a debug read port, one synchronous write port, and async active-low clear.
- The ALU is instantiated beside this block in the integration top, not inside it.

## Test plan
- Reset and loads:
  - Hold rst_n = 0, release → cmd_ready = 1, rsp_valid = 0, flag_v = 0, dbg_data = 0 for all addresses.
  - Load r0 = 4'h7, r1 = 4'h9 → each returns rsp_data equal to its immediate, 1 cycle after accept.
- Chained add:
  - Load r2 = 4'hF, r3 = 4'h1; ADD r2 + r3 → r0 → rsp_data = 4'h0, flag_v = 1, response 2 cycles after accept.
  - Then ADD r1 + r1 → r1 with cmd_use_carry = 1 (r1 = 4'h9 from the load) → alu_cin = 1, rsp_data = 4'h3.
- Flag hold in non-overflow modes:
  - With flag_v = 1, issue AND/OR/NOT/INC/DEC → flag_v stays 1, and the correct bitwise or ±1 results are written back.
- Response backpressure:
  - Hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid and rsp_data stay stable, cmd_ready = 0, and a new cmd_valid is not accepted.
- Reset mid-operation:
  - Pulse rst_n low during EXEC → regfile[dst] is unchanged from reset (0), no rsp_valid is produced, and the block returns to IDLE with cmd_ready = 1.
